// File: rtl/lcd_spi_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_spi_arbiter
//   Shares one W-bit LCD SPI word transmitter between a command requester
//   (init/config sequencer) and a pixel streamer. Whole transactions are
//   granted, the LCD chip select is driven here, and CS setup time and the
//   inter-transaction CS-high gap are enforced. Bit W-1 (D/C) is passed
//   through untouched.
//
//   Handshakes: a requester raises *_req with *_data/*_last stable and holds
//   them until *_ack, a 1-cycle pulse issued on the same cycle the word is
//   strobed into the SPI (spi_strobe). spi_ready is a level from the SPI:
//   a strobe is only issued on a cycle where spi_ready was sampled high.
//
// Ports
//   iClk, iRst_n                 clock, synchronous active-low reset
//   cmd_req/data/last, cmd_ack   command requester
//   pix_req/data/last, pix_ack   pixel requester
//   spi_ready, spi_data,
//   spi_strobe                   to/from spi_master
//   oLcdCs                       LCD chip select, active low
//   oOwner                       00 none, 01 cmd, 10 pix
//   oAbort                       1-cycle pulse on idle-timeout release
//   oState                       current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module lcd_spi_arbiter #(
    parameter int W        = 9,
    parameter int CS_SETUP = 2,
    parameter int CS_GAP   = 4,
    parameter int MAX_CMD  = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         cmd_req,
    input  logic [W-1:0] cmd_data,
    input  logic         cmd_last,
    output logic         cmd_ack,
    input  logic         pix_req,
    input  logic [W-1:0] pix_data,
    input  logic         pix_last,
    output logic         pix_ack,
    input  logic         spi_ready,
    output logic [W-1:0] spi_data,
    output logic         spi_strobe,
    output logic         oLcdCs,
    output logic [1:0]   oOwner,
    output logic         oAbort,
    output logic [2:0]   oState
);

    localparam int SW = $clog2(MAX_CMD + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CMD);
    localparam logic [7:0]    SETUP_END  = 8'(CS_SETUP - 1);
    localparam logic [7:0]    GAP_END    = 8'(CS_GAP - 1);
    localparam logic [7:0]    IDLE_END   = 8'(TIMEOUT - 1);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CMD  = 2'b01;
    localparam logic [1:0] OWN_PIX  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t        r_state;
    logic [7:0]    r_cnt;       // CS setup / CS gap cycle counter
    logic [7:0]    r_idle;      // cycles the owner has left its req low mid-transaction
    logic [SW-1:0] r_streak;    // consecutive cmd grants while pix was waiting
    logic          r_last;      // last flag of the word just strobed
    logic [1:0]    r_owner;
    logic          r_cs;
    logic [W-1:0]  r_spi_data;
    logic          r_strobe;
    logic          r_cmd_ack;
    logic          r_pix_ack;
    logic          r_abort;

    // Owner-side request mux; a non-owner request is simply invisible here.
    logic         w_own_is_cmd;
    logic         w_own_req;
    logic [W-1:0] w_own_data;
    logic         w_own_last;

    assign w_own_is_cmd = (r_owner == OWN_CMD);
    assign w_own_req    = w_own_is_cmd ? cmd_req  : ((r_owner == OWN_PIX) && pix_req);
    assign w_own_data   = w_own_is_cmd ? cmd_data : pix_data;
    assign w_own_last   = w_own_is_cmd ? cmd_last : pix_last;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idle     <= '0;
            r_streak   <= '0;
            r_last     <= 1'b0;
            r_owner    <= OWN_NONE;
            r_cs       <= 1'b1;
            r_spi_data <= '0;
            r_strobe   <= 1'b0;
            r_cmd_ack  <= 1'b0;
            r_pix_ack  <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_strobe  <= 1'b0;
            r_cmd_ack <= 1'b0;
            r_pix_ack <= 1'b0;
            r_abort   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    // Pix wins only when cmd is absent or has used up its streak.
                    if (pix_req && (!cmd_req || r_streak == STREAK_MAX)) begin
                        r_owner  <= OWN_PIX;
                        r_streak <= '0;
                        r_cs     <= 1'b0;
                        r_state  <= S_SETUP;
                    end else if (cmd_req) begin
                        r_owner <= OWN_CMD;
                        r_cs    <= 1'b0;
                        r_state <= S_SETUP;
                        if (!pix_req)
                            r_streak <= '0;
                        else if (r_streak != STREAK_MAX)
                            r_streak <= r_streak + 1'b1;
                    end else begin
                        r_owner <= OWN_NONE;
                    end
                end

                S_SETUP: begin
                    if (r_cnt == SETUP_END) begin
                        r_cnt   <= '0;
                        r_idle  <= '0;
                        r_state <= S_XFER;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_XFER: begin
                    if (w_own_req) begin
                        // Owner present but SPI busy: wait, idle counter holds.
                        if (spi_ready) begin
                            r_spi_data <= w_own_data;
                            r_strobe   <= 1'b1;
                            r_cmd_ack  <= w_own_is_cmd;
                            r_pix_ack  <= !w_own_is_cmd;
                            r_last     <= w_own_last;
                            r_idle     <= '0;
                            r_state    <= S_WAIT;
                        end
                    end else if (r_idle == IDLE_END) begin
                        r_abort <= 1'b1;
                        r_idle  <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_idle <= r_idle + 8'd1;
                    end
                end

                // One dead cycle after a strobe: spi_ready may not have fallen yet.
                S_WAIT: begin
                    r_state <= r_last ? S_DRAIN : S_XFER;
                end

                S_DRAIN: begin
                    if (spi_ready) begin
                        r_cs    <= 1'b1;
                        r_owner <= OWN_NONE;
                        r_cnt   <= '0;
                        r_state <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (r_cnt == GAP_END) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ack    = r_cmd_ack;
    assign pix_ack    = r_pix_ack;
    assign spi_data   = r_spi_data;
    assign spi_strobe = r_strobe;
    assign oLcdCs     = r_cs;
    assign oOwner     = r_owner;
    assign oAbort     = r_abort;
    assign oState     = r_state;

endmodule

// File: tb/tb_lcd_spi_arbiter.sv
// Testbench for lcd_spi_arbiter: requester driver processes fed from word
// queues, a simple SPI ready model, and a scoreboard of {owner, word}
// expected in strobe order.
module tb_lcd_spi_arbiter;

  localparam int W        = 9;
  localparam int CS_SETUP = 2;
  localparam int CS_GAP   = 4;
  localparam int MAX_CMD  = 4;
  localparam int TIMEOUT  = 255;

  // ---------------- clock / reset ----------------
  logic iClk = 1'b0;
  logic iRst_n;
  always #5 iClk = ~iClk;

  logic         cmd_req, cmd_last, cmd_ack;
  logic [W-1:0] cmd_data;
  logic         pix_req, pix_last, pix_ack;
  logic [W-1:0] pix_data;
  logic         spi_ready, spi_strobe;
  logic [W-1:0] spi_data;
  logic         oLcdCs, oAbort;
  logic [1:0]   oOwner;
  logic [2:0]   oState;

  lcd_spi_arbiter #(
    .W(W), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP), .MAX_CMD(MAX_CMD), .TIMEOUT(TIMEOUT)
  ) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .cmd_req(cmd_req), .cmd_data(cmd_data), .cmd_last(cmd_last), .cmd_ack(cmd_ack),
    .pix_req(pix_req), .pix_data(pix_data), .pix_last(pix_last), .pix_ack(pix_ack),
    .spi_ready(spi_ready), .spi_data(spi_data), .spi_strobe(spi_strobe),
    .oLcdCs(oLcdCs), .oOwner(oOwner), .oAbort(oAbort), .oState(oState)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- queues ----------------
  logic [W:0]   cmd_q[$];   // {last, data}
  logic [W:0]   pix_q[$];
  logic [W+1:0] exp_q[$];   // {owner, data} in expected strobe order
  logic         tst_cmd_req = 1'b0;

  // ---------------- requester drivers ----------------
  initial begin
    cmd_req = 1'b0; cmd_data = '0; cmd_last = 1'b0;
    forever begin
      @(negedge iClk);
      if (cmd_ack && cmd_q.size() > 0) void'(cmd_q.pop_front());
      if (cmd_q.size() > 0) begin
        cmd_req = 1'b1;
        {cmd_last, cmd_data} = cmd_q[0];
      end else begin
        cmd_req = tst_cmd_req; cmd_last = 1'b0; cmd_data = '0;
      end
    end
  end

  initial begin
    pix_req = 1'b0; pix_data = '0; pix_last = 1'b0;
    forever begin
      @(negedge iClk);
      if (pix_ack && pix_q.size() > 0) void'(pix_q.pop_front());
      if (pix_q.size() > 0) begin
        pix_req = 1'b1;
        {pix_last, pix_data} = pix_q[0];
      end else begin
        pix_req = 1'b0; pix_last = 1'b0; pix_data = '0;
      end
    end
  end

  // ---------------- SPI ready model ----------------
  int busy_len = 0;
  int busy_cnt = 0;
  initial begin
    spi_ready = 1'b1;
    forever begin
      @(negedge iClk);
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) spi_ready = 1'b1;
      end else if (spi_strobe && busy_len > 0) begin
        spi_ready = 1'b0;
        busy_cnt  = busy_len;
      end
    end
  end

  logic ready_at_edge = 1'b1;
  always @(posedge iClk) ready_at_edge <= spi_ready;

  // ---------------- monitor / scoreboard ----------------
  int   cyc = 0;
  int   last_strobe = -100;
  int   last_ack = 0;
  int   abort_cyc = 0;
  int   n_aborts = 0;
  int   n_strobes = 0;
  int   cs_high_cnt = 1000;
  int   cs_low_cnt = 0;
  logic first_strobe = 1'b0;
  logic prev_cs = 1'b1;
  logic prev_abort = 1'b0;
  logic [W+1:0] exp_word;

  always @(negedge iClk) begin
    cyc++;
    if (!iRst_n) begin
      cs_high_cnt  = 1000;
      first_strobe = 1'b0;
    end else begin
      if (oLcdCs) begin
        if (!prev_cs) check("cs_rise_ready", ready_at_edge, 1);
        cs_high_cnt++;
      end else begin
        if (prev_cs) begin
          check("cs_gap", cs_high_cnt >= CS_GAP, 1);
          cs_high_cnt  = 0;
          cs_low_cnt   = 0;
          first_strobe = 1'b1;
        end
        cs_low_cnt++;
      end

      if (spi_strobe) begin
        n_strobes++;
        check("strobe_ready", ready_at_edge, 1);
        check("strobe_cs", oLcdCs, 0);
        check("strobe_space", (cyc - last_strobe) >= 2, 1);
        last_strobe = cyc;
        if (first_strobe) begin
          check("cs_setup", (cs_low_cnt - 1) >= CS_SETUP, 1);
          first_strobe = 1'b0;
        end
        check("strobe_ack", {cmd_ack, pix_ack}, (oOwner == 2'b01) ? 2'b10 : 2'b01);
        check("exp_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_word = exp_q.pop_front();
          check("word", {oOwner, spi_data}, exp_word);
        end
      end

      if (cmd_ack || pix_ack) begin
        last_ack = cyc;
        check("ack_owner", oOwner, cmd_ack ? 1 : 2);
        check("ack_strobe", spi_strobe, 1);
      end

      if (oAbort) begin
        abort_cyc = cyc;
        n_aborts++;
        check("abort_pulse", prev_abort, 0);
      end
    end
    prev_cs    = oLcdCs;
    prev_abort = oAbort;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_cmd(input logic [W-1:0] d, input logic last);
    cmd_q.push_back({last, d});
    exp_q.push_back({2'b01, d});
  endtask

  task automatic push_pix(input logic [W-1:0] d, input logic last);
    pix_q.push_back({last, d});
    exp_q.push_back({2'b10, d});
  endtask

  // Wait until all queued words went out and the arbiter is back in IDLE.
  task automatic wait_done(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge iClk);
      if (exp_q.size() == 0 && cmd_q.size() == 0 && pix_q.size() == 0 &&
          oLcdCs && oOwner == 2'b00 && oState == 3'd0)
        done = 1'b1;
    end
    check(tag, done, 1);
    if (!done) begin
      cmd_q.delete(); pix_q.delete(); exp_q.delete();
      repeat (400) @(negedge iClk);
    end
  endtask

  // ---------------- tests ----------------
  int start;
  logic [W-1:0] rnd_word;

  initial begin
    iRst_n = 1'b0;
    tst_cmd_req = 1'b1;

    // 1: reset held with cmd_req high
    repeat (3) begin
      @(negedge iClk);
      check("rst_cs", oLcdCs, 1);
      check("rst_strobe", spi_strobe, 0);
      check("rst_ack", cmd_ack, 0);
      check("rst_owner", oOwner, 0);
    end
    tst_cmd_req = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b1;
    repeat (3) @(negedge iClk);
    check("rst_abort", oAbort, 0);

    // 2: single-word cmd transaction
    @(posedge iClk);
    push_cmd(9'h011, 1'b1);
    wait_done("t2_done", 100);

    // 3: both request together; cmd 3 words then pix 2 words
    @(posedge iClk);
    push_cmd(9'h02A, 1'b0); push_cmd(9'h100, 1'b0); push_cmd(9'h183, 1'b1);
    push_pix(9'h1C0, 1'b0); push_pix(9'h0FF, 1'b1);
    wait_done("t3_done", 200);

    // 4: fairness: 4 cmd txns, 1 pix txn, then cmd resumes
    @(posedge iClk);
    for (int i = 0; i < 6; i++) cmd_q.push_back({1'b1, 9'(9'h030 + i)});
    pix_q.push_back({1'b1, 9'h150});
    for (int i = 0; i < 4; i++) exp_q.push_back({2'b01, 9'(9'h030 + i)});
    exp_q.push_back({2'b10, 9'h150});
    for (int i = 4; i < 6; i++) exp_q.push_back({2'b01, 9'(9'h030 + i)});
    wait_done("t4_done", 400);

    // 5: timeout: pix sends one non-last word then goes quiet
    @(posedge iClk);
    start = n_aborts;
    push_pix(9'h1A5, 1'b0);
    for (int i = 0; i < 400 && n_aborts == start; i++) @(negedge iClk);
    check("abort_seen", n_aborts == start + 1, 1);
    // one WAIT cycle after the ack, then TIMEOUT idle cycles in XFER
    check("abort_lat", abort_cyc - last_ack, TIMEOUT + 1);
    @(posedge iClk);
    push_cmd(9'h0C3, 1'b1);
    wait_done("t5_done", 100);

    // 6: pacing with a slow SPI, random words
    busy_len = 10;
    @(posedge iClk);
    for (int i = 0; i < 4; i++) begin
      rnd_word = 9'($urandom_range(0, 511));
      push_cmd(rnd_word, i == 3);
    end
    wait_done("t6_done", 400);

    // 6b: reset in the middle of a pix transaction
    @(posedge iClk);
    start = n_strobes;
    for (int i = 0; i < 4; i++) push_pix(9'(9'h0E0 + i), i == 3);
    for (int i = 0; i < 100 && n_strobes == start; i++) @(negedge iClk);
    check("t6b_first", n_strobes > start, 1);
    iRst_n = 1'b0;
    pix_q.delete();
    exp_q.delete();
    @(negedge iClk);
    check("midrst_cs", oLcdCs, 1);
    check("midrst_strobe", spi_strobe, 0);
    check("midrst_owner", oOwner, 0);
    @(negedge iClk);
    iRst_n = 1'b1;
    start = n_strobes;
    repeat (30) @(negedge iClk);
    check("midrst_quiet", n_strobes, start);
    check("abort_count", n_aborts, 1);

    // recovery after reset
    busy_len = 0;
    @(posedge iClk);
    push_cmd(9'h1EE, 1'b1);
    wait_done("t7_done", 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
